// File: rtl/nes_pad_pkg.sv
// nes_pad_pkg: shared constants for the serial game-pad reader.
// Holds the poll FSM encoding, the button bit positions reported on the
// buttons/pressed vectors, and the NES/SNES shift lengths.
package nes_pad_pkg;

  // Poll sequencer states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LATCH  = 2'd1;
  localparam logic [1:0] ST_SHIFT  = 2'd2;
  localparam logic [1:0] ST_UPDATE = 2'd3;

  // Bit positions within one pad's field (8..11 exist on SNES pads only)
  localparam int BTN_AB     = 32'sd0;
  localparam int BTN_BY     = 32'sd1;
  localparam int BTN_SELECT = 32'sd2;
  localparam int BTN_START  = 32'sd3;
  localparam int BTN_UP     = 32'sd4;
  localparam int BTN_DOWN   = 32'sd5;
  localparam int BTN_LEFT   = 32'sd6;
  localparam int BTN_RIGHT  = 32'sd7;
  localparam int BTN_A      = 32'sd8;
  localparam int BTN_X      = 32'sd9;
  localparam int BTN_L      = 32'sd10;
  localparam int BTN_R      = 32'sd11;

  // Shift lengths of the two supported pad families
  localparam int NES_BITS  = 32'sd8;
  localparam int SNES_BITS = 32'sd12;

  // Start+Select held together asks the top level for a soft reset
  function automatic logic soft_reset_req(input logic sel, input logic start);
    return sel & start;
  endfunction

endpackage

// File: rtl/nes_pad_repeat.sv
// nes_pad_repeat: auto-repeat (DAS) timing for a single button.
// The counter tracks how many consecutive polls the button has been seen
// held. Once it reaches DAS_DELAY it cycles through DAS_DELAY..
// DAS_DELAY+DAS_RATE-1, so it never wraps to zero while held and cannot
// produce a spurious "new press" pulse. pulse is valid while update is high.
module nes_pad_repeat #(
  parameter int DAS_DELAY = 16,
  parameter int DAS_RATE  = 6
) (
  input  logic clk,
  input  logic reset_n,
  input  logic update,
  input  logic held,
  output logic pulse
);

  localparam int RW = $clog2(DAS_DELAY + DAS_RATE);
  localparam logic [RW-1:0] DELAY_V = RW'(DAS_DELAY);
  localparam logic [RW-1:0] WRAP_V  = RW'(DAS_DELAY + DAS_RATE - 1);

  logic [RW-1:0] cnt_r;

  // Pulse on a fresh press and each time the repeat window restarts
  assign pulse = held & ((cnt_r == {RW{1'b0}}) | (cnt_r == DELAY_V));

  // Advance the held-poll count at each poll update; release clears it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {RW{1'b0}};
    end else if (update) begin
      if (!held) begin
        cnt_r <= {RW{1'b0}};
      end else if (cnt_r == WRAP_V) begin
        cnt_r <= DELAY_V;
      end else begin
        cnt_r <= cnt_r + RW'(1'b1);
      end
    end
  end

endmodule

// File: rtl/nes_pad_reader.sv
// nes_pad_reader: polls PLAYERS serial NES/SNES pads on a shared latch/clock
// pair every POLL_CYCLES clocks and publishes held buttons, one-cycle press
// pulses and a Start+Select soft-reset request.
// Optional feature: define NES_PAD_AUTOREPEAT_EN to add per-button DAS
// auto-repeat pulses; otherwise pressed is a pure rising edge.
module nes_pad_reader
  import nes_pad_pkg::*;
#(
  parameter int PLAYERS     = 2,
  parameter int BITS        = 8,
  parameter int HALF        = 300,
  parameter int POLL_CYCLES = 833333,
  parameter int DAS_DELAY   = 16,
  parameter int DAS_RATE    = 6
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [PLAYERS-1:0]      pad_data,
  output logic                    pad_latch,
  output logic                    pad_clk,
  output logic [PLAYERS*BITS-1:0] buttons,
  output logic [PLAYERS*BITS-1:0] pressed,
  output logic                    sample_valid,
  output logic                    soft_reset
);

  localparam int NB = PLAYERS * BITS;
  localparam int PW = $clog2(POLL_CYCLES);
  localparam int CW = $clog2(2 * HALF);
  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(2 * HALF - 1);
  localparam logic [4:0]    BIT_LAST   = 5'(BITS - 1);

  // Reject configurations the poll timing cannot honour
  if (BITS < 8 || BITS > 16 || HALF < 1 || DAS_DELAY < 1 || DAS_RATE < 1 ||
      POLL_CYCLES <= 2 * HALF * (BITS + 1) + 2) begin : g_bad_params
    $error("nes_pad_reader: illegal parameter combination");
  end

  logic [PW-1:0]                poll_cnt_r;
  logic [1:0]                   state_r;
  logic [CW-1:0]                phase_r;
  logic [4:0]                   bit_r;
  logic                         pad_latch_r;
  logic                         pad_clk_r;
  logic [PLAYERS-1:0][BITS-1:0] shift_r;
  logic [NB-1:0]                shift_flat_s;
  logic [NB-1:0]                new_press_s;
  logic [NB-1:0]                buttons_r;
  logic [NB-1:0]                pressed_r;
  logic                         sample_valid_r;
  logic                         soft_reset_r;
  logic                         poll_tick_s;
  logic                         sample_s;

  assign poll_tick_s  = (poll_cnt_r == {PW{1'b0}});
  assign sample_s     = (state_r == ST_SHIFT) & ~pad_clk_r & (phase_r == HALF_LAST);
  assign shift_flat_s = shift_r;

  // Free-running poll period counter; zero marks a poll opportunity
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      poll_cnt_r <= {PW{1'b0}};
    end else if (poll_cnt_r == POLL_LAST) begin
      poll_cnt_r <= {PW{1'b0}};
    end else begin
      poll_cnt_r <= poll_cnt_r + PW'(1'b1);
    end
  end

  // Sequence latch pulse, shift clock phases and the update step of a poll
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      phase_r     <= {CW{1'b0}};
      bit_r       <= 5'd0;
      pad_latch_r <= 1'b0;
      pad_clk_r   <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (poll_tick_s) begin
            state_r     <= ST_LATCH;
            pad_latch_r <= 1'b1;
            phase_r     <= {CW{1'b0}};
          end
        end
        ST_LATCH: begin
          if (phase_r == LATCH_LAST) begin
            state_r     <= ST_SHIFT;
            pad_latch_r <= 1'b0;
            pad_clk_r   <= 1'b0;
            phase_r     <= {CW{1'b0}};
            bit_r       <= 5'd0;
          end else begin
            phase_r <= phase_r + CW'(1'b1);
          end
        end
        ST_SHIFT: begin
          if (phase_r == HALF_LAST) begin
            phase_r <= {CW{1'b0}};
            if (!pad_clk_r) begin
              // End of a low phase; the high phase after the last bit is skipped
              pad_clk_r <= 1'b1;
              if (bit_r == BIT_LAST) begin
                state_r <= ST_UPDATE;
              end
            end else begin
              pad_clk_r <= 1'b0;
              bit_r     <= bit_r + 5'd1;
            end
          end else begin
            phase_r <= phase_r + CW'(1'b1);
          end
        end
        ST_UPDATE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r     <= ST_IDLE;
          pad_latch_r <= 1'b0;
          pad_clk_r   <= 1'b1;
        end
      endcase
    end
  end

  // Capture each pad's inverted data bit; bit 0 ends up in position 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_r <= {NB{1'b0}};
    end else if (sample_s) begin
      for (int p = 0; p < PLAYERS; p++) begin
        shift_r[p] <= {~pad_data[p], shift_r[p][BITS-1:1]};
      end
    end
  end

`ifdef NES_PAD_AUTOREPEAT_EN
  logic update_s;
  assign update_s = (state_r == ST_UPDATE);

  for (genvar i = 0; i < NB; i++) begin : g_repeat
    nes_pad_repeat #(
      .DAS_DELAY (DAS_DELAY),
      .DAS_RATE  (DAS_RATE)
    ) u_repeat (
      .clk     (clk),
      .reset_n (reset_n),
      .update  (update_s),
      .held    (shift_flat_s[i]),
      .pulse   (new_press_s[i])
    );
  end
`else
  assign new_press_s = shift_flat_s & ~buttons_r;
`endif

  // Publish a completed poll; pulses last exactly one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buttons_r      <= {NB{1'b0}};
      pressed_r      <= {NB{1'b0}};
      sample_valid_r <= 1'b0;
      soft_reset_r   <= 1'b0;
    end else if (state_r == ST_UPDATE) begin
      buttons_r      <= shift_flat_s;
      pressed_r      <= new_press_s;
      sample_valid_r <= 1'b1;
      soft_reset_r   <= soft_reset_req(shift_r[0][BTN_SELECT], shift_r[0][BTN_START]);
    end else begin
      pressed_r      <= {NB{1'b0}};
      sample_valid_r <= 1'b0;
    end
  end

  assign pad_latch    = pad_latch_r;
  assign pad_clk      = pad_clk_r;
  assign buttons      = buttons_r;
  assign pressed      = pressed_r;
  assign sample_valid = sample_valid_r;
  assign soft_reset   = soft_reset_r;

endmodule

// File: tb/tb_nes_pad_reader.sv
// tb_nes_pad_reader: bench for nes_pad_reader with two SNES pads (BITS=12),
// HALF=2, 200-cycle polls. A timing/behaviour model derived from poll
// offsets checks every output each cycle; directed polls add literal checks.
// Honours NES_PAD_AUTOREPEAT_EN for the expected repeat pulses.
module tb_nes_pad_reader;

  localparam int PLAYERS = 2;
  localparam int BITS    = 12;
  localparam int HALF    = 2;
  localparam int POLL    = 200;
  localparam int DD      = 3;
  localparam int DR      = 2;
  localparam int NB      = PLAYERS * BITS;
  localparam int UPD     = 2 * HALF * BITS + HALF;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    pad_data;
  logic          pad_latch, pad_clk, sample_valid, soft_reset;
  logic [NB-1:0] buttons, pressed;

  always #5 clk = ~clk;

  nes_pad_reader #(
    .PLAYERS(PLAYERS), .BITS(BITS), .HALF(HALF), .POLL_CYCLES(POLL),
    .DAS_DELAY(DD), .DAS_RATE(DR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pad_data(pad_data),
    .pad_latch(pad_latch), .pad_clk(pad_clk), .buttons(buttons),
    .pressed(pressed), .sample_valid(sample_valid), .soft_reset(soft_reset)
  );

  // Pad model: latch loads the button state, each pad_clk rise shifts it
  logic [11:0] btn0 = 12'h000, btn1 = 12'h000;
  logic [11:0] sr0 = 12'h000, sr1 = 12'h000;
  always @(posedge pad_latch or posedge pad_clk) begin
    if (pad_latch) begin
      sr0 <= btn0;
      sr1 <= btn1;
    end else begin
      sr0 <= sr0 >> 1;
      sr1 <= sr1 >> 1;
    end
  end
  assign pad_data = {~sr1[0], ~sr0[0]};

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Rising clock edges since reset release
  int ticks = 0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) ticks <= 0;
    else ticks <= ticks + 1;
  end

  // Behavioural model and per-cycle comparison
  logic [NB-1:0] m_btn = '0, m_snap = '0, m_press;
  logic          m_soft = 1'b0;
  int            hc [NB];
  always @(negedge clk) begin : compare
    int   po;
    logic e_latch, e_clk, e_sv;
    m_press = '0;
    e_sv    = 1'b0;
    e_latch = 1'b0;
    e_clk   = 1'b1;
    if (!reset_n) begin
      m_btn  = '0;
      m_soft = 1'b0;
      for (int i = 0; i < NB; i++) hc[i] = 0;
    end else if (ticks > 0) begin
      po      = (ticks - 1) % POLL;
      e_latch = (po < 2 * HALF);
      e_clk   = !(po >= 2 * HALF && po < UPD && ((po - 2 * HALF) % (2 * HALF)) < HALF);
      if (po == 0) m_snap = {btn1, btn0};
      if (po == UPD + 1) begin
        e_sv = 1'b1;
        for (int i = 0; i < NB; i++) begin
          if (m_snap[i]) begin
`ifdef NES_PAD_AUTOREPEAT_EN
            if (hc[i] == 0 || hc[i] == DD || (hc[i] > DD && (hc[i] - DD) % DR == 0))
              m_press[i] = 1'b1;
            hc[i]++;
`else
            if (!m_btn[i]) m_press[i] = 1'b1;
`endif
          end else begin
            hc[i] = 0;
          end
        end
        m_btn  = m_snap;
        m_soft = m_snap[2] & m_snap[3];
      end
    end
    chk("pad_latch", pad_latch, e_latch);
    chk("pad_clk", pad_clk, e_clk);
    chk("sample_valid", sample_valid, e_sv);
    chk("buttons", buttons, m_btn);
    chk("pressed", pressed, m_press);
    chk("soft_reset", soft_reset, m_soft);
  end

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * POLL && !ok; i++) begin
      @(negedge clk);
      if (sample_valid === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL wait_valid: no sample_valid within %0d cycles", 3 * POLL);
    end
  endtask

  task automatic poll(input logic [11:0] p0, input logic [11:0] p1, output bit ok);
    btn0 = p0;
    btn1 = p1;
    wait_valid(ok);
  endtask

  initial begin : stim
    bit ok;
    int n, cnt;
    btn0 = 12'h008;
    btn1 = 12'h000;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_latch", pad_latch, 1'b0);
    chk("rst_clk", pad_clk, 1'b1);
    chk("rst_buttons", buttons, 24'h0);
    chk("rst_valid", sample_valid, 1'b0);
    chk("rst_soft", soft_reset, 1'b0);
    reset_n = 1'b1;

    // First poll: latency of latch, first clock fall and update
    n = 0;
    do begin @(negedge clk); n++; end while (pad_latch !== 1'b1 && n < 10);
    chk("latch_delay", n, 1);
    n = 0;
    while (pad_clk !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    chk("clk_fall_cycle", n, 4);
    while (sample_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("valid_cycle", n, 51);
    chk("start_buttons", buttons, 24'h000008);
    chk("start_pressed", pressed, 24'h000008);
    cnt = int'(pressed[3]);

    // Start held for five polls in total
    for (int i = 0; i < 4; i++) begin
      poll(12'h008, 12'h000, ok);
      chk("hold_buttons", buttons, 24'h000008);
      cnt += int'(pressed[3]);
    end
`ifdef NES_PAD_AUTOREPEAT_EN
    chk("hold_start_pulses", cnt, 2);
`else
    chk("hold_start_pulses", cnt, 1);
`endif
    poll(12'h000, 12'h000, ok);
    chk("release_buttons", buttons, 24'h0);
    chk("release_pressed", pressed, 24'h0);

    // Right held ten polls, released, pressed again
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      poll(12'h080, 12'h000, ok);
      cnt += int'(pressed[7]);
    end
`ifdef NES_PAD_AUTOREPEAT_EN
    chk("right_pulses", cnt, 5);
`else
    chk("right_pulses", cnt, 1);
`endif
    poll(12'h000, 12'h000, ok);
    chk("right_release", pressed, 24'h0);
    poll(12'h080, 12'h000, ok);
    chk("right_repress", pressed, 24'h000080);

    // Start+Select soft reset request
    poll(12'h00C, 12'h000, ok);
    chk("soft_set", soft_reset, 1'b1);
    chk("soft_buttons", buttons, 24'h00000C);
    poll(12'h000, 12'h000, ok);
    chk("soft_clear", soft_reset, 1'b0);

    // Player 1 presses R (SNES bit 11)
    poll(12'h000, 12'h800, ok);
    chk("p1_r_buttons", buttons, 24'h800000);
    chk("p1_r_pressed", pressed, 24'h800000);

    // Reset in the first low cycle of bit 5
    n = 0;
    do begin @(negedge clk); n++; end while (pad_latch !== 1'b1 && n < 400);
    repeat (24) @(negedge clk);
    chk("bit5_clk_low", pad_clk, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_latch", pad_latch, 1'b0);
    chk("midrst_clk", pad_clk, 1'b1);
    chk("midrst_buttons", buttons, 24'h0);
    chk("midrst_valid", sample_valid, 1'b0);
    repeat (2) @(negedge clk);
    btn0 = 12'h0A5;
    btn1 = 12'h800;
    #1 reset_n = 1'b1;
    wait_valid(ok);
    chk("after_rst_buttons", buttons, 24'h8000A5);
    chk("after_rst_pressed", pressed, 24'h8000A5);
    chk("after_rst_soft", soft_reset, 1'b0);
    poll(12'h0A5, 12'h800, ok);
    chk("after_rst_hold", pressed, 24'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
